// File: rtl/gcd_host_driver.sv
// Host-side sequencer for the subtractive GCD engine: request/response handshakes,
// zero-operand short-circuit and a WAIT cycle budget with engine abort.
module gcd_host_driver #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_gcd,
  output logic             rsp_err,
  output logic             start,
  output logic [WIDTH-1:0] data_in,
  output logic             eng_abort,
  input  logic             done,
  input  logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic             err_q, err_d;
  logic             start_q, start_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             abort_q, abort_d;

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    gcd_d       = gcd_q;
    err_d       = err_q;
    start_d     = 1'b0;
    data_d      = '0;
    abort_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          b_d         = req_b;
          req_ready_d = 1'b0;
          if (req_a != '0 && req_b != '0) begin
            state_d = LOAD_A;
            start_d = 1'b1;
            data_d  = req_a;
          end else begin
            // gcd(x,0)=x; both zero has no defined result
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            gcd_d       = req_a | req_b;
            err_d       = (req_a == '0) && (req_b == '0);
          end
        end
      end
      LOAD_A: begin
        state_d = LOAD_B;
        data_d  = b_q;
      end
      LOAD_B: state_d = WAIT;
      WAIT: begin
        cnt_d = cnt_inc;
        // first WAIT cycle may still show the previous run's done
        if (cnt_q != '0 && done) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          gcd_d       = result;
          err_d       = 1'b0;
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          abort_d     = 1'b1;
          gcd_d       = '0;
          err_d       = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cnt_d       = '0;
          req_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      b_q         <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      gcd_q       <= '0;
      err_q       <= 1'b0;
      start_q     <= 1'b0;
      data_q      <= '0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      gcd_q       <= gcd_d;
      err_q       <= err_d;
      start_q     <= start_d;
      data_q      <= data_d;
      abort_q     <= abort_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_gcd   = gcd_q;
  assign rsp_err   = err_q;
  assign start     = start_q;
  assign data_in   = data_q;
  assign eng_abort = abort_q;

endmodule

// File: tb/tb_gcd_host_driver.sv
// Scoreboard bench for gcd_host_driver: behavioural subtractive engine, Euclid reference,
// plus a second instance with a short budget and a silent engine for the abort path.
module tb_gcd_host_driver;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [15:0] req_a = '0, req_b = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [15:0] rsp_gcd, data_in;
  logic        start, eng_abort;
  logic        done = 1'b0;
  logic [15:0] result = '0;

  logic        req_valid_t = 1'b0, req_ready_t, rsp_valid_t, rsp_ready_t = 1'b0, rsp_err_t;
  logic [15:0] req_a_t = '0, req_b_t = '0, rsp_gcd_t, data_in_t;
  logic        start_t, eng_abort_t;
  logic        done_t = 1'b0;
  logic [15:0] result_t = '0;

  always #5 clock = ~clock;

  gcd_host_driver #(.WIDTH(16), .TIMEOUT(1024)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_gcd(rsp_gcd), .rsp_err(rsp_err), .start(start), .data_in(data_in),
    .eng_abort(eng_abort), .done(done), .result(result));

  gcd_host_driver #(.WIDTH(16), .TIMEOUT(8)) dut_to (
    .clock(clock), .reset(reset), .req_valid(req_valid_t), .req_ready(req_ready_t),
    .req_a(req_a_t), .req_b(req_b_t), .rsp_valid(rsp_valid_t), .rsp_ready(rsp_ready_t),
    .rsp_gcd(rsp_gcd_t), .rsp_err(rsp_err_t), .start(start_t), .data_in(data_in_t),
    .eng_abort(eng_abort_t), .done(done_t), .result(result_t));

  typedef struct {logic [15:0] g; logic e;} exp_t;
  exp_t exp_q[$];
  int   tests = 0, fails = 0;
  int   nstart = 0, nrsp = 0, npush = 0;
  bit   hold_low = 1'b0, prev_start = 1'b0;

  function automatic exp_t gcd_ref(input logic [15:0] a, input logic [15:0] b);
    exp_t r;
    logic [15:0] x = a, y = b, t;
    r.e = (a == 0) && (b == 0);
    while (y != 0) begin t = x % y; x = y; y = t; end
    r.g = r.e ? 16'd0 : x;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Engine: loads A on start, B next cycle, drops a stale done one cycle later, then subtracts.
  int          ph = 0;
  logic [15:0] ea = '0, eb = '0;
  always @(posedge clock) begin
    if (reset || eng_abort) begin ph <= 0; done <= 1'b0; end
    else if (start) begin ea <= data_in; ph <= 1; end
    else case (ph)
      1: begin eb <= data_in; ph <= 2; end
      2: begin done <= 1'b0; ph <= 3; end
      3: if (ea == eb) begin done <= 1'b1; result <= ea; ph <= 0; end
         else if (ea > eb) ea <= ea - eb;
         else eb <= eb - ea;
      default: ;
    endcase
  end

  always @(posedge clock) begin
    #1 rsp_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  always @(negedge clock) begin
    if (!reset && rsp_valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_rsp: got gcd=%0d err=%0d, expected no response", rsp_gcd, rsp_err);
      end else begin
        if (rsp_gcd !== exp_q[0].g || rsp_err !== exp_q[0].e || req_ready !== 1'b0) begin
          fails++;
          $display("FAIL rsp: got gcd=%0d err=%0d req_ready=%0d, expected gcd=%0d err=%0d req_ready=0",
                   rsp_gcd, rsp_err, req_ready, exp_q[0].g, exp_q[0].e);
        end
        if (rsp_ready) begin void'(exp_q.pop_front()); nrsp++; end
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      if ((start && prev_start) || (start && eng_abort)) begin
        tests++; fails++;
        $display("FAIL start_proto: got start=%0d prev=%0d abort=%0d, expected single start without abort",
                 start, prev_start, eng_abort);
      end
      if (start) nstart++;
    end
    prev_start = start;
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input bit push);
    int n = 0;
    while (!req_ready && n < 5000) begin @(negedge clock); n++; end
    if (!req_ready) chk("req_ready_wait", 0, 1);
    req_valid = 1'b1; req_a = a; req_b = b;
    if (push) begin exp_q.push_back(gcd_ref(a, b)); npush++; end
    @(posedge clock); #1;
    req_valid = 1'b0; req_a = 16'($urandom); req_b = 16'($urandom);
    @(negedge clock);
    if (a != 0 && b != 0) begin
      chk("load_a", {15'd0, start, data_in}, {15'd1, a});
      @(negedge clock);
      chk("load_b", {15'd0, start, data_in}, {15'd0, b});
    end else begin
      chk("zero_path", {30'd0, rsp_valid, start}, 32'd2);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 3000) begin @(negedge clock); n++; end
    if (exp_q.size() != 0 || !req_ready) chk("idle_wait", 0, 1);
  endtask

  task automatic chk_reset_vals(input string name);
    chk(name, {req_ready, rsp_valid, start, eng_abort, rsp_err, data_in, rsp_gcd},
        {5'b10000, 16'd0, 16'd0});
  endtask

  initial begin
    int s0, rv_at, ab_at, ab_cnt;
    logic [15:0] a, b;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_reset_vals("reset_state");
    reset = 1'b0;

    s0 = nstart; issue(16'd48, 16'd18, 1'b1); wait_idle();
    chk("one_start_48_18", nstart - s0, 1);
    issue(16'd9, 16'd6, 1'b1); wait_idle();

    s0 = nstart;
    issue(16'd0, 16'd35, 1'b1); issue(16'd0, 16'd0, 1'b1); wait_idle();
    chk("zero_no_start", nstart - s0, 0);

    hold_low = 1'b1; @(negedge clock);
    issue(16'd100, 16'd75, 1'b1);
    for (int i = 0; i < 300 && !rsp_valid; i++) @(negedge clock);
    chk("bp_rsp_valid", rsp_valid, 1);
    repeat (5) @(negedge clock);
    hold_low = 1'b0; wait_idle();

    issue(16'd1000, 16'd1, 1'b0);
    repeat (20) @(negedge clock);
    reset = 1'b1; @(posedge clock); #1;
    chk_reset_vals("mid_wait_reset");
    reset = 1'b0;
    repeat (3) @(negedge clock);
    issue(16'd12, 16'd8, 1'b1); wait_idle();

    for (int k = 0; k < 40; k++) begin
      a = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 255));
      b = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 255));
      issue(a, b, 1'b1);
    end
    wait_idle();
    chk("rsp_count", nrsp, npush);

    @(negedge clock);
    chk("to_req_ready", req_ready_t, 1);
    req_a_t = 16'd7; req_b_t = 16'd7; req_valid_t = 1'b1;
    @(posedge clock); #1 req_valid_t = 1'b0;
    rv_at = -1; ab_at = -1; ab_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (eng_abort_t) begin ab_cnt++; if (ab_at < 0) ab_at = c; end
      if (rsp_valid_t && rv_at < 0) rv_at = c;
    end
    chk("to_rsp_latency", rv_at, 11);
    chk("to_abort_latency", ab_at, 11);
    chk("to_abort_pulses", ab_cnt, 1);
    chk("to_rsp", {rsp_err_t, rsp_gcd_t}, {1'b1, 16'd0});
    rsp_ready_t = 1'b1;
    @(negedge clock); @(negedge clock);
    chk("to_back_idle", {rsp_valid_t, req_ready_t}, 2'b01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
